// File: rtl/delta_2nd_frame_window_writer.sv
// Write side of the delta-2nd frame window: 5-slot circular frame buffer
// with a handshaked window presented to the reader.
//
// Ports:
//   clk, rst_n           clock and synchronous active-low reset
//   start, frame_total   utterance start pulse and frame count
//   in_valid/in_data     coefficient stream, in_ready accepts
//   win_valid/win_frame  window resident, index of newest frame
//   win_ack              reader releases the window
//   rd_offset/rd_addr    frame within window / coefficient index
//   rd_data              registered read data
//   done                 end-of-utterance pulse
module delta_2nd_frame_window_writer #(
    parameter int DATA_WIDTH          = 16,
    parameter int COEF_NUM            = 13,
    parameter int COUNTER_VALUE_WIDTH = 7,
    localparam int ADDR_WIDTH = (COEF_NUM > 1) ? $clog2(COEF_NUM) : 1,
    localparam int CW         = COUNTER_VALUE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CW-1:0]         frame_total,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  win_valid,
    output logic [CW-1:0]         win_frame,
    input  logic                  win_ack,
    input  logic [2:0]            rd_offset,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  done
);

    localparam int DEPTH = 5 * COEF_NUM;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WINDOW,
        DONE
    } state_t;

    state_t state, state_n;

    logic [CW-1:0]         total;
    logic [CW-1:0]         total_m1;
    logic [CW-1:0]         wr_frame;
    logic [CW-1:0]         win_frame_q;
    logic [ADDR_WIDTH-1:0] coef_cnt;
    logic [2:0]            newest_slot;

    logic accept;
    logic last_coef;
    logic load;
    logic advance;
    logic enter_win;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_idx;
    logic [3:0]            slot_sum;
    logic [2:0]            rd_slot;
    logic [AW-1:0]         rd_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    assign accept    = in_valid && (state == FILL);
    assign last_coef = (coef_cnt == ADDR_WIDTH'(COEF_NUM - 1));
    assign total_m1  = total - CW'(1);

    assign in_ready  = (state == FILL);
    assign win_valid = (state == WINDOW);
    assign done      = (state == DONE);
    assign win_frame = win_frame_q;

    always_comb begin
        state_n   = state;
        load      = 1'b0;
        advance   = 1'b0;
        enter_win = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_n = (frame_total == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                if (accept && last_coef) begin
                    if (wr_frame >= CW'(4)) begin
                        state_n   = WINDOW;
                        enter_win = 1'b1;
                    end else if (wr_frame == total_m1) begin
                        state_n = DONE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            WINDOW: begin
                if (win_ack) begin
                    if (win_frame_q == total_m1) begin
                        state_n = DONE;
                    end else begin
                        advance = 1'b1;
                        state_n = FILL;
                    end
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Slot of the oldest frame sits right after the newest one; a single
    // subtract covers every legal offset (sum never exceeds 9).
    always_comb begin
        slot_sum = {1'b0, newest_slot} + 4'd1 + {1'b0, rd_offset};
        if (slot_sum >= 4'd5) begin
            slot_sum = slot_sum - 4'd5;
        end
        rd_slot = slot_sum[2:0];
        rd_idx  = AW'(rd_slot) * AW'(COEF_NUM) + AW'(rd_addr);
        rd_word = (rd_idx < AW'(DEPTH)) ? mem[rd_idx] : '0;
    end

    assign wr_idx = AW'(newest_slot) * AW'(COEF_NUM) + AW'(coef_cnt);

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_idx] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            total       <= '0;
            wr_frame    <= '0;
            win_frame_q <= '0;
            coef_cnt    <= '0;
            newest_slot <= '0;
            rd_data     <= '0;
        end else begin
            state   <= state_n;
            rd_data <= rd_word;
            if (load) begin
                total       <= frame_total;
                wr_frame    <= '0;
                win_frame_q <= '0;
                coef_cnt    <= '0;
                newest_slot <= '0;
            end
            if (accept) begin
                coef_cnt <= last_coef ? '0 : coef_cnt + 1'b1;
            end
            if (advance) begin
                wr_frame    <= wr_frame + 1'b1;
                newest_slot <= (newest_slot == 3'd4) ? 3'd0
                                                     : newest_slot + 3'd1;
            end
            if (enter_win) begin
                win_frame_q <= wr_frame;
            end
        end
    end

endmodule

// File: tb/tb_delta_2nd_frame_window_writer.sv
// Directed bench for delta_2nd_frame_window_writer.
// Frame f coefficient i carries base + 16*f + i.
module tb_delta_2nd_frame_window_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [6:0]  frame_total;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        win_valid;
    logic [6:0]  win_frame;
    logic        win_ack;
    logic [2:0]  rd_offset;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic        done;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int win_cyc = 0;

    delta_2nd_frame_window_writer dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .frame_total(frame_total),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .win_valid(win_valid),
        .win_frame(win_frame),
        .win_ack(win_ack),
        .rd_offset(rd_offset),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;
        if (win_valid) win_cyc <= win_cyc + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic [6:0] n);
        frame_total = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic ack();
        win_ack = 1'b1;
        tick();
        win_ack = 1'b0;
    endtask

    task automatic rd(input int off, input int addr, input int exp,
                      input string tag);
        rd_offset = 3'(off);
        rd_addr   = 4'(addr);
        tick();
        check(tag, 32'(rd_data), exp);
    endtask

    // poke: inside the first frame, pulse start (with a different
    // frame_total) and win_ack, both of which FILL must ignore.
    task automatic stream(input int first, input int count, input int base,
                          input bit poke);
        int n;
        for (int f = first; f < first + count; f++) begin
            for (int i = 0; i < 13; i++) begin
                in_valid = 1'b1;
                in_data  = 16'(base + 16 * f + i);
                if (poke && f == first && i == 6) begin
                    start = 1'b1;
                    frame_total = 7'd3;
                end
                if (poke && f == first && i == 9) win_ack = 1'b1;
                n = 0;
                while (!in_ready && n < 100) begin
                    tick();
                    n++;
                end
                if (!in_ready) begin
                    check("stream_timeout", 32'(in_ready), 1);
                    in_valid = 1'b0;
                    return;
                end
                tick();
                start   = 1'b0;
                win_ack = 1'b0;
                if (poke) frame_total = 7'd12;
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int a0;
        int w0;
        int rdy;
        rst_n = 1'b0;
        start = 1'b0;
        frame_total = '0;
        in_valid = 1'b0;
        in_data = '0;
        win_ack = 1'b0;
        rd_offset = '0;
        rd_addr = '0;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_win_valid", 32'(win_valid), 0);
        check("rst_done", 32'(done), 0);
        check("rst_win_frame", 32'(win_frame), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        rst_n = 1'b1;
        tick();

        // basic window
        pulse_start(7'd5);
        check("basic_start_ready", 32'(in_ready), 1);
        stream(0, 5, 0, 1'b0);
        check("basic_win_valid", 32'(win_valid), 1);
        check("basic_win_frame", 32'(win_frame), 4);
        check("basic_in_ready", 32'(in_ready), 0);
        rd(0, 3, 'h0003, "basic_rd_oldest");
        rd(4, 12, 'h004C, "basic_rd_newest");
        ack();
        check("basic_done", 32'(done), 1);
        check("basic_win_drop", 32'(win_valid), 0);
        w0 = win_cyc;
        tick();
        check("basic_done_once", 32'(done), 0);
        repeat (10) tick();
        check("basic_no_more_win", 32'(win_cyc - w0), 0);
        check("basic_idle_ready", 32'(in_ready), 0);

        // backpressure, ignored inputs and slot wrap
        pulse_start(7'd12);
        stream(0, 5, 0, 1'b0);
        check("wrap_first_valid", 32'(win_valid), 1);
        rd(2, 5, 'h0025, "bp_rd_before");
        a0 = acc_cnt;
        rdy = 0;
        in_valid = 1'b1;
        in_data = 16'hDEAD;
        repeat (50) begin
            tick();
            if (in_ready) rdy++;
        end
        in_valid = 1'b0;
        check("bp_in_ready", 32'(rdy), 0);
        check("bp_accepts", 32'(acc_cnt - a0), 0);
        check("bp_win_valid", 32'(win_valid), 1);
        check("bp_rd_data", 32'(rd_data), 'h0025);
        for (int w = 4; w < 12; w++) begin
            check("wrap_valid", 32'(win_valid), 1);
            check("wrap_frame", 32'(win_frame), w);
            rd(0, 0, 16 * (w - 4), "wrap_oldest");
            rd(4, 1, 16 * w + 1, "wrap_newest");
            if (w == 11) begin
                for (int o = 0; o < 5; o++) begin
                    rd(o, 7, 16 * (7 + o) + 7, "wrap_w11");
                end
            end
            ack();
            if (w < 11) begin
                check("wrap_ack_ready", 32'(in_ready), 1);
                stream(w + 1, 1, 0, w == 4);
            end
        end
        check("wrap_done", 32'(done), 1);
        tick();
        check("wrap_done_once", 32'(done), 0);

        // three-frame utterance
        pulse_start(7'd3);
        a0 = acc_cnt;
        w0 = win_cyc;
        stream(0, 3, 0, 1'b0);
        check("short3_done", 32'(done), 1);
        check("short3_accepts", 32'(acc_cnt - a0), 39);
        check("short3_no_win", 32'(win_cyc - w0), 0);
        tick();
        check("short3_done_once", 32'(done), 0);

        // empty utterance
        pulse_start(7'd0);
        check("zero_done", 32'(done), 1);
        check("zero_in_ready", 32'(in_ready), 0);
        tick();
        check("zero_done_once", 32'(done), 0);
        check("zero_idle_ready", 32'(in_ready), 0);

        // reset mid-utterance
        pulse_start(7'd12);
        stream(0, 5, 0, 1'b0);
        check("mid_win_valid", 32'(win_valid), 1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_in_ready", 32'(in_ready), 0);
        check("mid_rst_win_valid", 32'(win_valid), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_win_frame", 32'(win_frame), 0);
        check("mid_rst_rd_data", 32'(rd_data), 0);
        rst_n = 1'b1;
        tick();
        pulse_start(7'd6);
        stream(0, 5, 'h800, 1'b0);
        check("mid_w4_valid", 32'(win_valid), 1);
        check("mid_w4_frame", 32'(win_frame), 4);
        rd(0, 1, 'h0801, "mid_w4_oldest");
        rd(4, 2, 'h0842, "mid_w4_newest");
        ack();
        stream(5, 1, 'h800, 1'b0);
        check("mid_w5_valid", 32'(win_valid), 1);
        check("mid_w5_frame", 32'(win_frame), 5);
        rd(0, 0, 'h0810, "mid_w5_oldest");
        rd(4, 12, 'h085C, "mid_w5_newest");
        ack();
        check("mid_done", 32'(done), 1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
